// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop length, 3-sample
// majority voting, input synchroniser, start-glitch rejection, framing/parity/break flags.
module uart_rx_param #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned OVS     = 16,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned PARITY  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            busy
);

    localparam int unsigned SW = $clog2(SB_TICK);
    localparam int unsigned NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_VOTE0    = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_VOTE1    = SW'(OVS / 2);
    localparam logic [SW-1:0] S_VOTE2    = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_BIT_END  = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StBrkWait
    } state_e;

    state_e          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [1:0]      smp_q;
    logic [DBIT-1:0] shreg_q;
    logic            par_q;
    logic            stop_q;

    logic vote;
    logic par_mis;
    logic is_break;

    // Third sample is taken live from rx_s on the vote tick.
    assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

    always_comb begin
        par_mis = 1'b0;
        if (PARITY == 1) begin
            par_mis = (^shreg_q) ^ par_q;
        end else if (PARITY == 2) begin
            par_mis = ~((^shreg_q) ^ par_q);
        end
    end

    assign is_break = (shreg_q == '0) && ((PARITY == 0) || !par_q) && !stop_q;
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            s_q          <= '0;
            n_q          <= '0;
            smp_q        <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            rx_done_tick <= 1'b0;
            rx_dout      <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            rx_done_tick <= 1'b0;

            if (s_tick && (state_q != StIdle) && (state_q != StBrkWait)) begin
                if (s_q == S_VOTE0) smp_q[0] <= rx_s_q;
                if (s_q == S_VOTE1) smp_q[1] <= rx_s_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_q <= StStart;
                        s_q     <= '0;
                    end
                end
                StStart: begin
                    if (s_tick) begin
                        if ((s_q == S_VOTE2) && vote) begin
                            state_q <= StIdle;
                        end else if (s_q == S_BIT_END) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            state_q <= StData;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (s_tick) begin
                        if (s_q == S_VOTE2) shreg_q <= {vote, shreg_q[DBIT-1:1]};
                        if (s_q == S_BIT_END) begin
                            s_q <= '0;
                            if (n_q == N_LAST) begin
                                state_q <= (PARITY != 0) ? StPar : StStop;
                            end else begin
                                n_q <= n_q + 1'b1;
                            end
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                StPar: begin
                    if (s_tick) begin
                        if (s_q == S_VOTE2) par_q <= vote;
                        if (s_q == S_BIT_END) begin
                            s_q     <= '0;
                            state_q <= StStop;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (s_tick) begin
                        if (s_q == S_VOTE2) stop_q <= vote;
                        // stop_q was voted earlier in the stop period, so it is valid here.
                        if (s_q == S_STOP_END) begin
                            s_q          <= '0;
                            rx_done_tick <= 1'b1;
                            rx_dout      <= is_break ? '0 : shreg_q;
                            parity_err   <= par_mis;
                            frame_err    <= !stop_q;
                            break_det    <= is_break;
                            state_q      <= is_break ? StBrkWait : StIdle;
                        end else begin
                            s_q <= s_q + 1'b1;
                        end
                    end
                end
                StBrkWait: begin
                    if (rx_s_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8N1 UART receiver.
- Adds configurable data width, optional even/odd parity and configurable stop length.
- Adds 3-sample majority voting, an input synchroniser, start-glitch rejection, and framing-error, parity-error and break detection.
- Sits between the serial pin and the RX FIFO. It is driven by the shared oversampling tick from timer_input, and rx_done_tick is the FIFO write strobe.

Parameters:
- DBIT, 8, data bits per frame, legal 5..9, LSB first.
- OVS, 16, s_tick periods per bit, even, >=8.
- SB_TICK, 16, s_tick periods of stop time (16/24/32 = 1/1.5/2 stop bits at OVS=16), >=OVS.
- PARITY, 0, 0=none, 1=even, 2=odd.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- rx, input, 1, asynchronous serial line, idle high.
- s_tick, input, 1, one-clk pulse, OVS per bit period.
- rx_done_tick, output, 1, one-clk pulse per completed frame.
- rx_dout, output, DBIT, received data; updated with rx_done_tick, held otherwise.
- parity_err, output, 1, parity mismatch of last frame; 0 when PARITY=0.
- frame_err, output, 1, stop-bit vote was 0 for last frame.
- break_det, output, 1, last frame was a break.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset values:
  - rx_dout=0; rx_done_tick, parity_err, frame_err, break_det, busy = 0.
  - Synchroniser flops = 1; state=IDLE; counters = 0.
  - Reset mid-frame aborts the frame with no done pulse.
- Synchroniser:
  - 2-FF on rx gives rx_s. All decisions use rx_s, adding 2 clk of latency.
- Counters:
  - s counts s_tick within a bit, width clog2(SB_TICK).
  - n is the bit index, width clog2(DBIT).
  - s and n advance only on s_tick.
- Majority vote:
  - Sample rx_s on s_tick at s = OVS/2-1, OVS/2 and OVS/2+1.
  - The bit value is the majority of the 3 samples.
- States: IDLE, START, DATA, PAR, STOP, BRK_WAIT.
  - IDLE: rx_s==0 → START with s=0. No tick is needed to leave IDLE.
  - START:
    - At vote completion (s==OVS/2+1), vote 1 → IDLE (glitch): no outputs change, no done.
    - Vote 0 → continue. At s==OVS-1 with s_tick: s=0, n=0, go to DATA.
  - DATA:
    - Vote result shifts in MSB-first into the shift register (shift right), so the LSB arrives first.
    - At s==OVS-1: if n==DBIT-1, go to PAR (PARITY≠0) or STOP; else n+1.
  - PAR:
    - Vote gives p.
    - Mismatch rule: even mismatch when XOR(data,p)=1; odd mismatch when XOR(data,p)=0.
    - At s==OVS-1, go to STOP.
  - STOP:
    - Vote on the first stop bit gives the frame_err source (vote 0 → error).
    - At s==SB_TICK-1 with s_tick, the next clk pulses rx_done_tick.
    - On that same clk, rx_dout, parity_err, frame_err and break_det load.
    - If break, go to BRK_WAIT; else go to IDLE.
  - Break definition:
    - All data votes 0, parity vote 0 (if present) and stop vote 0.
    - On break: break_det=1, frame_err=1, rx_dout=0.
  - BRK_WAIT: stay until rx_s==1, then go to IDLE. No new frame starts while the line is low.
- Status flags:
  - parity_err, frame_err and break_det are levels qualified by rx_done_tick.
  - They hold until the next done.
- Back-to-back frames:
  - A start edge on the clk after STOP→IDLE is accepted; no extra idle is required.
- Tick coincidence:
  - s_tick arriving on the same clk as the IDLE→START transition is not counted.

Test Plan:
- Common setup for all scenarios:
  - timer_input FINAL_VALUE=15 gives s_tick every 16 clk.
  - OVS=16, so one bit = 256 clk.
- 8N1, send 0xAB → one rx_done_tick; rx_dout=0xAB; parity_err=frame_err=break_det=0; busy falls within 2 clk of done.
- PARITY=1 (even):
  - Send 0x55 with p=0 → parity_err=0.
  - Send 0x55 with p=1 → parity_err=1, rx_dout=0x55.
  - PARITY=2: 0x01 with p=0 → parity_err=0.
- Start glitch: rx low for 4 ticks, then high → no rx_done_tick; busy returns 0 by s==OVS/2+2.
- Noise: invert rx for 1 tick at s==OVS/2 of data bit 3 of 0xF0 → rx_dout=0xF0 (majority corrects).
- Framing and break:
  - 0x3C with stop=0 → frame_err=1, break_det=0.
  - rx low for 12 bit times → one done, rx_dout=0x00, frame_err=1, break_det=1; no second done until rx high and a new start.
- Back-to-back and reset:
  - Send 0x00 then 0xFF with no idle gap → two dones, correct data.
  - Assert reset mid-DATA → outputs 0, no done; the next frame 0x5A is received correctly.
